// File: rtl/rv_instr_encoder.sv
// Packs field-level RV32I instruction descriptors into 32-bit words and writes
// them sequentially into instruction memory during a load session.
module rv_instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              ovf,
    output logic [ADDR_W:0]   word_count
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state;
    logic              out_valid;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              accept;
    logic              wr_done;
    logic [31:0]       enc_word;
    logic              enc_bad;
    logic              sext12;
    logic              sext13;
    logic              sext21;

    assign accept   = in_valid && in_ready;
    assign wr_done  = out_valid && mem_ready;
    assign ptr_nxt  = wr_done ? ptr + ADDR_W'(1) : ptr;
    assign in_ready = (state == LOAD) && (!out_valid || mem_ready);
    assign mem_we   = out_valid;
    assign mem_addr = ptr;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Immediate must be a pure sign extension of its encodable field.
    assign sext12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign sext13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign sext21 = (in_imm[31:20] == {12{in_imm[20]}});

    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        case (in_fmt)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_bad  = !sext12;
            end
            3'd2: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_bad  = !sext12;
            end
            3'd3: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_bad  = !sext13 || in_imm[0];
            end
            3'd4: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                enc_bad  = (in_imm[11:0] != 12'd0);
            end
            3'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_bad  = !sext21 || in_imm[0];
            end
            default: enc_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            ptr        <= ADDR_W'(BASE_ADDR);
            mem_wdata  <= 32'd0;
            err        <= 1'b0;
            err_addr   <= '0;
            ovf        <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        ptr        <= ADDR_W'(BASE_ADDR);
                        err        <= 1'b0;
                        ovf        <= 1'b0;
                        word_count <= '0;
                    end
                end
                LOAD:  if (accept && in_last) state <= DRAIN;
                // Leave as soon as the pending word completes so done follows the last write.
                DRAIN: if (!out_valid || mem_ready) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (wr_done) begin
                ptr <= ptr + ADDR_W'(1);
                if (ptr == {ADDR_W{1'b1}}) ovf <= 1'b1;
                if (word_count != {CNT_W{1'b1}}) word_count <= word_count + CNT_W'(1);
            end

            // A completing write and a new accept in the same cycle reload without a bubble.
            if (accept) begin
                out_valid <= 1'b1;
                mem_wdata <= enc_bad ? NOP : enc_word;
                if (enc_bad) begin
                    err <= 1'b1;
                    if (!err) err_addr <= ptr_nxt;
                end
            end else if (wr_done) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Randomized bench for rv_instr_encoder: a field-level scoreboard model checks
// two instances (10-bit and 2-bit address) driven with the same descriptor stream.
module tb_rv_instr_encoder;
    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        bit          has_gold;
        logic [31:0] gold;
    } desc_t;

    logic clk, rst_n, start, in_valid, in_last, mem_ready;
    logic [2:0] in_fmt, in_funct3;
    logic [6:0] in_opcode, in_funct7;
    logic [4:0] in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;

    logic a_in_ready, a_mem_we, a_busy, a_done, a_err, a_ovf;
    logic [9:0] a_mem_addr, a_err_addr;
    logic [31:0] a_mem_wdata;
    logic [10:0] a_wc;
    logic b_in_ready, b_mem_we, b_busy, b_done, b_err, b_ovf;
    logic [1:0] b_mem_addr, b_err_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0] b_wc;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 1;
    desc_t cur;
    desc_t dq[$];

    rv_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(a_mem_we), .mem_ready(mem_ready), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .busy(a_busy), .done(a_done), .err(a_err), .err_addr(a_err_addr), .ovf(a_ovf),
        .word_count(a_wc));

    rv_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(b_mem_we), .mem_ready(mem_ready), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .busy(b_busy), .done(b_done), .err(b_err), .err_addr(b_err_addr), .ovf(b_ovf),
        .word_count(b_wc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder written from the format tables with shifts and range tests.
    function automatic logic [31:0] model_enc(input desc_t d, output bit bad);
        logic [31:0] w;
        logic [31:0] u;
        int s;
        u = d.imm;
        s = $signed(d.imm);
        w = 32'(d.op);
        bad = 1'b0;
        case (d.fmt)
            3'd0: w |= (32'(d.f7) << 25) | (32'(d.rs2) << 20) | (32'(d.rs1) << 15)
                     | (32'(d.f3) << 12) | (32'(d.rd) << 7);
            3'd1: begin
                bad = (s < -2048) || (s > 2047);
                w |= ((u & 32'hFFF) << 20) | (32'(d.rs1) << 15) | (32'(d.f3) << 12) | (32'(d.rd) << 7);
            end
            3'd2: begin
                bad = (s < -2048) || (s > 2047);
                w |= (((u >> 5) & 32'h7F) << 25) | (32'(d.rs2) << 20) | (32'(d.rs1) << 15)
                   | (32'(d.f3) << 12) | ((u & 32'h1F) << 7);
            end
            3'd3: begin
                bad = (s < -4096) || (s > 4094) || (u % 2 != 0);
                w |= (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(d.rs2) << 20)
                   | (32'(d.rs1) << 15) | (32'(d.f3) << 12) | (((u >> 1) & 32'hF) << 8)
                   | (((u >> 11) & 1) << 7);
            end
            3'd4: begin
                bad = (u % 4096) != 0;
                w |= (u & 32'hFFFF_F000) | (32'(d.rd) << 7);
            end
            3'd5: begin
                bad = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (u % 2 != 0);
                w |= (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
                   | (((u >> 12) & 32'hFF) << 12) | (32'(d.rd) << 7);
            end
            default: bad = 1'b1;
        endcase
        return bad ? 32'h0000_0013 : w;
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        d.fmt = ($urandom % 10 == 0) ? 3'(6 + $urandom % 2) : 3'($urandom % 6);
        d.op  = 7'($urandom); d.f3 = 3'($urandom); d.f7 = 7'($urandom);
        d.rd  = 5'($urandom); d.rs1 = 5'($urandom); d.rs2 = 5'($urandom);
        case (d.fmt)
            3'd1, 3'd2: d.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            3'd3:       d.imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            3'd4:       d.imm = $urandom & 32'hFFFF_F000;
            3'd5:       d.imm = (32'($urandom_range(0, (1 << 20) - 1)) - 32'(1 << 19)) << 1;
            default:    d.imm = $urandom;
        endcase
        if ($urandom % 6 == 0) d.imm = $urandom;
        d.has_gold = 1'b0;
        d.gold = 32'd0;
        return d;
    endfunction

    task automatic add_d(input int fmt, input int op, input int f3, input int f7, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm, input logic [31:0] gold);
        desc_t d;
        d.fmt = 3'(fmt); d.op = 7'(op); d.f3 = 3'(f3); d.f7 = 7'(f7);
        d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.imm = imm;
        d.has_gold = 1'b1; d.gold = gold;
        dq.push_back(d);
    endtask

    initial begin
        int cyc;
        cyc = 0;
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0: mem_ready = ($urandom % 3) != 0;
                2: mem_ready = (cyc % 5) >= 3;
                3: mem_ready = 1'b0;
                default: mem_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard: expected words in write order, session flags, sticky status.
    initial begin
        logic [31:0] q[$];
        logic [31:0] e;
        bit sess, sess0, in_load, last_acc, exp_done, err_m, bad, ir_exp, we_exp;
        int wcnt, acc_cnt, ea_a, ea_b;
        sess = 0; in_load = 0; last_acc = 0; exp_done = 0; err_m = 0;
        wcnt = 0; acc_cnt = 0; ea_a = 0; ea_b = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                sess = 0; in_load = 0; last_acc = 0; exp_done = 0; err_m = 0;
                wcnt = 0; acc_cnt = 0; ea_a = 0; ea_b = 0;
            end else begin
                sess0  = sess;
                we_exp = (q.size() != 0);
                ir_exp = in_load && (!we_exp || mem_ready);
                check("mem_we_a", a_mem_we, we_exp);
                check("mem_we_b", b_mem_we, we_exp);
                check("in_ready_a", a_in_ready, ir_exp);
                check("in_ready_b", b_in_ready, ir_exp);
                check("busy_a", a_busy, sess);
                check("busy_b", b_busy, sess);
                check("done_a", a_done, exp_done);
                check("done_b", b_done, exp_done);
                if (exp_done) begin
                    check("err_a", a_err, err_m);
                    check("err_b", b_err, err_m);
                    check("err_addr_a", a_err_addr, ea_a);
                    check("err_addr_b", b_err_addr, ea_b);
                    check("ovf_a", a_ovf, wcnt >= 1024);
                    check("ovf_b", b_ovf, wcnt >= 4);
                    check("word_count_a", a_wc, (wcnt > 2047) ? 2047 : wcnt);
                    check("word_count_b", b_wc, (wcnt > 7) ? 7 : wcnt);
                    sess = 0;
                    exp_done = 0;
                end
                if (we_exp && mem_ready) begin
                    e = q.pop_front();
                    check("mem_addr_a", a_mem_addr, wcnt % 1024);
                    check("mem_wdata_a", a_mem_wdata, e);
                    check("mem_addr_b", b_mem_addr, wcnt % 4);
                    check("mem_wdata_b", b_mem_wdata, e);
                    wcnt++;
                    if (q.size() == 0 && last_acc) begin
                        exp_done = 1;
                        last_acc = 0;
                    end
                end
                if (start && !sess0) begin
                    sess = 1; in_load = 1; wcnt = 0; acc_cnt = 0; err_m = 0;
                end
                if (in_valid && ir_exp) begin
                    e = model_enc(cur, bad);
                    q.push_back(cur.has_gold ? cur.gold : e);
                    if (bad && !err_m) begin
                        ea_a = acc_cnt % 1024;
                        ea_b = acc_cnt % 4;
                    end
                    if (bad) err_m = 1;
                    acc_cnt++;
                    if (in_last) begin
                        in_load = 0;
                        last_acc = 1;
                    end
                end
            end
        end
    end

    task automatic start_session();
        bit ok;
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (!a_busy) ok = 1;
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_desc(input desc_t d, input bit last, input bit gaps);
        bit ok;
        if (gaps) repeat ($urandom % 3) begin @(posedge clk); #1; end
        cur = d;
        in_fmt = d.fmt; in_opcode = d.op; in_funct3 = d.f3; in_funct7 = d.f7;
        in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2; in_imm = d.imm;
        in_last = last;
        in_valid = 1'b1;
        start = gaps && ($urandom % 5 == 0);
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (a_in_ready) ok = 1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    endtask

    task automatic run_session(input bit gaps);
        bit ok;
        start_session();
        foreach (dq[i]) send_desc(dq[i], i == dq.size() - 1, gaps);
        ok = 0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            if (a_done) ok = 1;
        end
        if (!ok) check("done_timeout", 0, 1);
        @(posedge clk); #1;
        dq.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        cur = rand_desc();
        #2;
        check("rst_mem_we", a_mem_we, 0);
        check("rst_busy", a_busy, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_word_count", a_wc, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic encodes, back to back.
        rdy_mode = 1;
        add_d(1, 7'h13, 0, 0, 1, 0, 0, 32'd5, 32'h0050_0093);
        add_d(0, 7'h33, 0, 0, 3, 1, 2, 32'd0, 32'h0020_81B3);
        add_d(2, 7'h23, 2, 0, 0, 1, 2, 32'd8, 32'h0020_A423);
        run_session(0);
        check("basic_word_count", a_wc, 3);

        // Immediate scrambling.
        add_d(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFE00_0EE3);
        add_d(5, 7'h6F, 0, 0, 1, 0, 0, 32'd8, 32'h0080_00EF);
        add_d(4, 7'h37, 0, 0, 5, 0, 0, 32'h1234_5000, 32'h1234_52B7);
        run_session(0);

        // Encode errors: first at word 4, a later one must not move err_addr.
        for (int i = 0; i < 4; i++) add_d(1, 7'h13, 0, 0, 1, 0, 0, 32'(i), 32'h0000_0013 | (32'(i) << 20) | 32'h80);
        add_d(1, 7'h13, 0, 0, 1, 0, 0, 32'd2048, 32'h0000_0013);
        add_d(3, 7'h63, 0, 0, 0, 0, 0, 32'd3, 32'h0000_0013);
        add_d(0, 7'h33, 0, 0, 3, 1, 2, 32'd0, 32'h0020_81B3);
        run_session(0);
        check("err_set", a_err, 1);
        check("err_addr_first", a_err_addr, 4);
        add_d(0, 7'h33, 0, 0, 3, 1, 2, 32'd0, 32'h0020_81B3);
        run_session(0);
        check("err_cleared", a_err, 0);

        // Backpressure with 3-cycle stalls.
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) dq.push_back(rand_desc());
        run_session(0);

        // Pointer wrap on the 2-bit instance.
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) dq.push_back(rand_desc());
        run_session(0);
        check("wrap_ovf_b", b_ovf, 1);
        check("wrap_count_b", b_wc, 5);

        // Random sessions.
        for (int s = 0; s < 25; s++) begin
            rdy_mode = $urandom % 3;
            for (int i = 0; i < 1 + $urandom % 12; i++) dq.push_back(rand_desc());
            run_session(1);
        end

        // Long session wraps the 10-bit pointer.
        rdy_mode = 1;
        for (int i = 0; i < 1030; i++) dq.push_back(rand_desc());
        run_session(0);

        // Reset mid-LOAD with a word pending.
        rdy_mode = 3;
        start_session();
        dq.delete();
        add_d(1, 7'h13, 0, 0, 1, 0, 0, 32'd5, 32'h0050_0093);
        send_desc(dq[0], 1'b0, 1'b0);
        dq.delete();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", a_mem_we, 0);
        check("midrst_in_ready", a_in_ready, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_done", a_done, 0);
        check("midrst_err", a_err, 0);
        check("midrst_ovf", a_ovf, 0);
        check("midrst_mem_addr", a_mem_addr, 0);
        check("midrst_mem_wdata", a_mem_wdata, 0);
        check("midrst_err_addr", a_err_addr, 0);
        check("midrst_word_count", a_wc, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 1;
        add_d(5, 7'h6F, 0, 0, 1, 0, 0, 32'd8, 32'h0080_00EF);
        add_d(4, 7'h37, 0, 0, 5, 0, 0, 32'h1234_5000, 32'h1234_52B7);
        run_session(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rv_instr_encoder.md
# rv_instr_encoder

Instruction encoder and loader: the inverse of the core's instruction decoder. Accepts one field-level instruction descriptor per handshake (format, opcode, funct fields, register indices, full 32-bit immediate), packs it into a 32-bit RV32I instruction word, and writes it sequentially into instruction memory. It sits between the boot/debug program source and the instruction memory write port, and is used to load programs before the CPU is released from reset.

## Interface

- `ADDR_W`, 10: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begins a load session; ignored outside IDLE.
- `in_valid`  in  1  descriptor valid.
- `in_ready`  out  1  descriptor accepted when `in_valid && in_ready`.
- `in_fmt`  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6–7 invalid.
- `in_opcode`  in  7  inst[6:0].
- `in_funct3`  in  3  used by R, I, S and B.
- `in_funct7`  in  7  used by R only.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  32  signed byte-offset or value; U uses bits [31:12].
- `in_last`  in  1  final descriptor of the session.
- `mem_we`  out  1  write request.
- `mem_ready`  in  1  memory accepts the write when `mem_we && mem_ready`.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  encoded instruction.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at session end.
- `err`  out  1  sticky encode error; cleared by `start`.
- `err_addr`  out  ADDR_W  address of the first erroneous word.
- `ovf`  out  1  sticky write-pointer wrap; cleared by `start`.
- `word_count`  out  ADDR_W+1  words written this session.

## Operation

- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: `start` moves to LOAD. On entry to LOAD: pointer = BASE_ADDR, and `err`, `ovf` and `word_count` are cleared.
  - LOAD: accepts descriptors. An accepted descriptor with `in_last` moves to DRAIN.
  - DRAIN: waits until the output register is empty, then moves to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
  - `start` in any state other than IDLE is ignored.
- Output register holds one encoded word.
  - `mem_we` equals output-register valid.
  - `in_ready` = (state==LOAD) && (!out_valid || mem_ready).
- Encoding (low bits always `in_opcode`):
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Encode errors:
  - I/S: imm is not the sign extension of imm[11:0].
  - B: imm is not the sign extension of imm[12:0], or imm[0]=1.
  - J: imm is not the sign extension of imm[20:0], or imm[0]=1.
  - U: imm[11:0]≠0.
  - fmt 6 or 7.
- On an encode error:
  - the word written is 0x00000013 (NOP);
  - `err` is set;
  - `err_addr` latches the word's address only if `err` was previously 0.
- Pointer:
  - increments by 1 on each completed write, modulo 2^ADDR_W.
  - An increment from all-ones sets `ovf`; writing continues.
- `word_count` increments on each completed write and saturates at its maximum.

## Timing

- Latency: a descriptor accepted at edge N produces `mem_we`=1 with stable addr/data during cycle N+1.
- Throughput is 1 word/cycle while `mem_ready`=1.
- `mem_addr` and `mem_wdata` are held stable while `mem_we && !mem_ready`.
- Simultaneous write completion and new accept in the same cycle: the output register reloads with no bubble.
- `done` asserts the cycle after the last write completes.
- Reset (async, any state, mid-session included):
  - state=IDLE;
  - `mem_we`, `in_ready`, `busy`, `done`, `err`, `ovf` = 0;
  - `mem_addr` = BASE_ADDR;
  - `mem_wdata`, `err_addr`, `word_count` = 0.
  - An in-flight word is dropped.

## Test plan

- Basic encodes with `mem_ready`=1, `start` then back-to-back descriptors:
  - I addi x1,x0,5 → 0x00500093 @0;
  - R add x3,x1,x2 → 0x002081B3 @1;
  - S sw x2,8(x1) → 0x0020A423 @2;
  - `in_last` on the third → `done` pulse; `word_count`=3.
- Immediate scrambling:
  - B beq x0,x0,-4 → 0xFE000EE3;
  - J jal x1,8 → 0x008000EF;
  - U lui x5 imm=0x12345000 → 0x123452B7.
- Encode errors:
  - I with imm=2048 at addr 4 → NOP 0x00000013 written, `err`=1, `err_addr`=4;
  - a later B with imm=3 keeps `err_addr`=4;
  - the next `start` clears `err`.
- Backpressure: hold `mem_ready`=0 for 3 cycles with a word pending → `in_ready`=0, addr/data unchanged, no duplicate write; release → one write, then accepts resume.
- Wrap: `ADDR_W`=2, 5 descriptors → addrs 0,1,2,3,0; `ovf`=1 after the 4th write; `word_count`=5.
- Reset mid-LOAD with a pending word → all outputs at reset values immediately; a new `start` begins at BASE_ADDR.
